// File: rtl/avalon_slave_registros.sv
`default_nettype none
// ============================================================================
// Module      : avalon_slave_registros
// Description : Avalon-MM register-bank slave with programmable wait states,
//               a combinational core-side read port and a write-notify pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_slave_registros #(
   parameter int DATA_BITS    = 8,
   parameter int ADDRESS_BITS = 5,
   parameter int WAIT_CYCLES  = 2   // legal range 0..15
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [ADDRESS_BITS-1:0] avalon_address,
   input  logic                    avalon_read,
   input  logic                    avalon_write,
   input  logic [DATA_BITS-1:0]    avalon_write_data,
   output logic [DATA_BITS-1:0]    avalon_read_data,
   output logic                    avalon_wait_request,
   input  logic [ADDRESS_BITS-1:0] local_direccion,
   output logic [DATA_BITS-1:0]    local_dato,
   output logic                    nuevo_dato,
   output logic [ADDRESS_BITS-1:0] direccion_escrita,
   output logic [DATA_BITS-1:0]    dato_escrito
);

   localparam int         C_DEPTH     = 1 << ADDRESS_BITS;
   localparam logic [3:0] C_WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [3:0]           r_counter;
   logic [3:0]           w_next_counter;
   logic                 w_req;
   logic                 w_wait;
   logic                 w_complete;
   logic [DATA_BITS-1:0] r_bank [C_DEPTH];

   assign w_req = avalon_read | avalon_write;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_counter <= 4'd0;
      end else begin
         r_state   <= w_next_state;
         r_counter <= w_next_counter;
      end
   end

   always_comb begin
      w_next_state   = r_state;
      w_next_counter = r_counter;
      w_wait         = 1'b0;
      w_complete     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               if (WAIT_CYCLES == 0) begin
                  w_complete   = 1'b1;
                  w_next_state = S_DONE;
               end else begin
                  w_wait         = 1'b1;
                  w_next_counter = C_WAIT_LOAD;
                  w_next_state   = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            w_wait = (r_counter != 4'd0);
            // A master that abandons the request mid-wait gets no side effects.
            if (!w_req) begin
               w_next_counter = 4'd0;
               w_next_state   = S_IDLE;
            end else if (r_counter != 4'd0) begin
               w_next_counter = r_counter - 4'd1;
            end else begin
               w_complete   = 1'b1;
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            w_wait       = w_req;
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state   = S_IDLE;
            w_next_counter = 4'd0;
         end
      endcase
   end

   // Held low throughout reset regardless of any pending request.
   assign avalon_wait_request = reset_n & w_wait;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < C_DEPTH; i++) begin
            r_bank[i] <= '0;
         end
         avalon_read_data  <= '0;
         nuevo_dato        <= 1'b0;
         direccion_escrita <= '0;
         dato_escrito      <= '0;
      end else begin
         nuevo_dato <= 1'b0;
         if (w_complete) begin
            // Write takes priority when read and write arrive together.
            if (avalon_write) begin
               r_bank[avalon_address] <= avalon_write_data;
               direccion_escrita      <= avalon_address;
               dato_escrito           <= avalon_write_data;
               nuevo_dato             <= 1'b1;
            end else begin
               avalon_read_data <= r_bank[avalon_address];
            end
         end
      end
   end

   assign local_dato = r_bank[local_direccion];

endmodule
`default_nettype wire

// File: tb/tb_avalon_slave_registros.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_slave_registros
// Description : Self-checking bench, two slaves (2 and 0 wait states).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_slave_registros;

   logic       clk;
   logic       reset_n;
   logic [4:0] addr;
   logic [7:0] wdata;
   logic [4:0] ldir;
   logic       rd_in [2];
   logic       wr_in [2];
   logic [7:0] rdat  [2];
   logic       wreq  [2];
   logic [7:0] ldat  [2];
   logic       nuevo [2];
   logic [4:0] dir   [2];
   logic [7:0] dat   [2];

   int checks;
   int errors;

   // Reference model: bank contents and last-observed register values per slave
   logic [7:0] m_bank [2][32];
   logic [7:0] m_rd   [2];
   logic [4:0] m_dir  [2];
   logic [7:0] m_dat  [2];

   typedef struct {
      int         s;
      bit         rd;
      bit         wr;
      logic [4:0] a;
      logic [7:0] d;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t tbl [9];

   avalon_slave_registros #(.DATA_BITS(8), .ADDRESS_BITS(5), .WAIT_CYCLES(2)) u_dut_w2 (
      .clk                 (clk),
      .reset_n             (reset_n),
      .avalon_address      (addr),
      .avalon_read         (rd_in[0]),
      .avalon_write        (wr_in[0]),
      .avalon_write_data   (wdata),
      .avalon_read_data    (rdat[0]),
      .avalon_wait_request (wreq[0]),
      .local_direccion     (ldir),
      .local_dato          (ldat[0]),
      .nuevo_dato          (nuevo[0]),
      .direccion_escrita   (dir[0]),
      .dato_escrito        (dat[0])
   );

   avalon_slave_registros #(.DATA_BITS(8), .ADDRESS_BITS(5), .WAIT_CYCLES(0)) u_dut_w0 (
      .clk                 (clk),
      .reset_n             (reset_n),
      .avalon_address      (addr),
      .avalon_read         (rd_in[1]),
      .avalon_write        (wr_in[1]),
      .avalon_write_data   (wdata),
      .avalon_read_data    (rdat[1]),
      .avalon_wait_request (wreq[1]),
      .local_direccion     (ldir),
      .local_dato          (ldat[1]),
      .nuevo_dato          (nuevo[1]),
      .direccion_escrita   (dir[1]),
      .dato_escrito        (dat[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int nwait(input int s);
      return (s == 0) ? 2 : 0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 32; i++) m_bank[s][i] = 8'h00;
         m_rd[s]  = 8'h00;
         m_dir[s] = 5'd0;
         m_dat[s] = 8'h00;
      end
   endtask

   // One complete access: request held until wait_request falls, then released.
   task automatic access(input int s, input bit rd, input bit wr,
                         input logic [4:0] a, input logic [7:0] d);
      int n;
      n = nwait(s);
      @(negedge clk);
      addr     = a;
      wdata    = d;
      rd_in[s] = rd;
      wr_in[s] = wr;
      for (int c = 0; c <= n; c++) begin
         #1;
         check("wait_request", 32'(wreq[s]), (c < n) ? 32'd1 : 32'd0);
         @(negedge clk);
      end
      rd_in[s] = 1'b0;
      wr_in[s] = 1'b0;
      ldir     = a;
      if (wr) begin
         m_bank[s][a] = d;
         m_dir[s]     = a;
         m_dat[s]     = d;
      end else if (rd) begin
         m_rd[s] = m_bank[s][a];
      end
      #1;
      check("recovery_wait", 32'(wreq[s]), 32'd0);
      check("nuevo_dato", 32'(nuevo[s]), 32'(wr));
      check("direccion_escrita", 32'(dir[s]), 32'(m_dir[s]));
      check("dato_escrito", 32'(dat[s]), 32'(m_dat[s]));
      check("read_data", 32'(rdat[s]), 32'(m_rd[s]));
      check("local_dato", 32'(ldat[s]), 32'(m_bank[s][a]));
      @(negedge clk);
      #1;
      check("nuevo_clear", 32'(nuevo[s]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout watchdog expired");
      $fatal(1, "bench timeout");
   end

   initial begin
      int k;
      logic [4:0] ra;
      logic [7:0] rd8;
      checks   = 0;
      errors   = 0;
      reset_n  = 1'b0;
      addr     = '0;
      wdata    = '0;
      ldir     = '0;
      rd_in[0] = 1'b0; rd_in[1] = 1'b0;
      wr_in[0] = 1'b0; wr_in[1] = 1'b0;
      model_reset();

      tbl[0] = '{0, 1'b0, 1'b1, 5'd3,  8'h5A, 8'h00};
      tbl[1] = '{0, 1'b1, 1'b0, 5'd3,  8'h00, 8'h5A};
      tbl[2] = '{0, 1'b1, 1'b1, 5'd7,  8'hC3, 8'h5A};
      tbl[3] = '{0, 1'b1, 1'b0, 5'd7,  8'h00, 8'hC3};
      tbl[4] = '{0, 1'b0, 1'b1, 5'd31, 8'hAA, 8'hC3};
      tbl[5] = '{0, 1'b1, 1'b0, 5'd31, 8'h00, 8'hAA};
      tbl[6] = '{0, 1'b1, 1'b0, 5'd0,  8'h00, 8'h00};
      tbl[7] = '{1, 1'b0, 1'b1, 5'd5,  8'h77, 8'h00};
      tbl[8] = '{1, 1'b1, 1'b0, 5'd5,  8'h00, 8'h77};

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         check("rst_wait", 32'(wreq[s]), 32'd0);
         check("rst_read_data", 32'(rdat[s]), 32'd0);
         check("rst_nuevo", 32'(nuevo[s]), 32'd0);
         check("rst_dir", 32'(dir[s]), 32'd0);
         check("rst_dato", 32'(dat[s]), 32'd0);
         check("rst_local", 32'(ldat[s]), 32'd0);
      end
      @(negedge clk);
      reset_n = 1'b1;

      // Directed vectors
      for (int i = 0; i < 9; i++) begin
         access(tbl[i].s, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
         check("tbl_read_data", 32'(rdat[tbl[i].s]), 32'(tbl[i].exp_rd));
      end

      // Zero wait states: write immediately followed by a read held through recovery
      @(negedge clk);
      addr = 5'd0; wdata = 8'h11; wr_in[1] = 1'b1;
      #1;
      check("w0_write_wait", 32'(wreq[1]), 32'd0);
      @(negedge clk);
      wr_in[1] = 1'b0; rd_in[1] = 1'b1;
      #1;
      check("w0_done_pending_wait", 32'(wreq[1]), 32'd1);
      check("w0_nuevo", 32'(nuevo[1]), 32'd1);
      check("w0_dato", 32'(dat[1]), 32'h11);
      @(negedge clk);
      #1;
      check("w0_read_wait", 32'(wreq[1]), 32'd0);
      @(negedge clk);
      rd_in[1] = 1'b0;
      #1;
      check("w0_read_data", 32'(rdat[1]), 32'h11);
      check("w0_idle_wait", 32'(wreq[1]), 32'd0);
      m_bank[1][0] = 8'h11; m_dir[1] = 5'd0; m_dat[1] = 8'h11; m_rd[1] = 8'h11;

      // Reset asserted while a write is in its wait states
      @(negedge clk);
      addr = 5'd1; wdata = 8'hFF; wr_in[0] = 1'b1;
      #1;
      check("rw_wait0", 32'(wreq[0]), 32'd1);
      @(negedge clk);
      #1;
      check("rw_wait1", 32'(wreq[0]), 32'd1);
      reset_n = 1'b0;
      ldir    = 5'd1;
      #1;
      check("rw_wait_forced", 32'(wreq[0]), 32'd0);
      check("rw_bank1", 32'(ldat[0]), 32'd0);
      @(negedge clk);
      wr_in[0] = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      #1;
      check("rw_nuevo", 32'(nuevo[0]), 32'd0);
      check("rw_dir", 32'(dir[0]), 32'd0);
      check("rw_bank1_after", 32'(ldat[0]), 32'd0);
      ldir = 5'd7;
      #1;
      check("rw_bank7_cleared", 32'(ldat[0]), 32'd0);
      access(0, 1'b0, 1'b1, 5'd1, 8'h3C);
      access(0, 1'b1, 1'b0, 5'd1, 8'h00);

      // Randomized accesses against the model
      for (int i = 0; i < 80; i++) begin
         k   = int'($urandom_range(0, 3));
         ra  = 5'($urandom_range(0, 31));
         rd8 = 8'($urandom_range(0, 255));
         access(int'($urandom_range(0, 1)), (k >= 2), (k != 2), ra, rd8);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
